pu_da_dtlb_fa: RTL and testbench
================================

Name: pu_da_dtlb_fa

Overview:
Parametrised, fully associative data TLB for the PU data-access stage. It translates the virtual D-cache tag to a physical tag with one-cycle registered latency. Each entry carries a thread ID, a global bit, a non-cacheable attribute and a kernel-only permission bit. Software maintains entries via a write port with indexed or round-robin placement and bulk invalidation. When on=0 it behaves as an identity pass-through: registered vtag appears as ptag.

Parameters:
ENTRIES, 8, number of TLB entries (power of 2, >=2)
TAG_W, 20, virtual/physical tag width (matches PU_DC_TAG_W)
TID_W, 2, thread ID width (matches PuTidBus)
IDX_W, $clog2(ENTRIES), entry index width (derived, not overridable)

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
req  in  1  lookup valid this cycle
tid  in  TID_W  requesting thread
tmode  in  1  1=kernel, 0=user
on  in  1  translation enable
vtag  in  TAG_W  virtual tag
ptag  out  TAG_W  physical tag (registered)
nc  out  1  non-cacheable (registered)
hit  out  1  lookup hit (registered)
miss  out  1  lookup miss (registered)
fault  out  1  permission fault (registered)
multi  out  1  multiple entries matched (registered, diagnostic)
sw_we  in  1  software entry write
sw_rr  in  1  1=write at round-robin pointer, 0=write at sw_idx
sw_idx  in  IDX_W  explicit write index
sw_vtag, sw_ptag  in  TAG_W  entry tags
sw_tid  in  TID_W  entry thread ID
sw_glb, sw_nc, sw_kern  in  1  global, non-cacheable and kernel-only bits
sw_inv_all  in  1  invalidate all entries
sw_inv_tid  in  1  invalidate non-global entries whose tid equals sw_tid
rr_ptr  out  IDX_W  current replacement pointer

Behaviour:
- Reset, asynchronous: all entry valid bits 0, rr_ptr 0. ptag 0; nc, hit, miss, fault and multi all 0. Entry payload fields are don't-care.
- Lookup latency: inputs sampled at edge N; outputs valid after edge N. Outputs are updated only when req=1. When req=0: hit/miss/fault/multi go to 0 next cycle, ptag and nc hold their values.
- on=0 with req=1: ptag<=vtag, nc<=0, hit<=1, miss<=0, fault<=0, multi<=0. This is the legacy identity mode.
- on=1 match for entry i: V[i] && vtag==VT[i] && (G[i] || tid==T[i]).
- Any match: hit<=1; ptag and nc taken from the lowest-index matching entry; fault<=K[sel] && !tmode. multi<=1 if more than one entry matched.
- No match: miss<=1, hit<=0, fault<=0, ptag holds, nc<=0.
- Write: on sw_we, the target entry (rr_ptr if sw_rr, else sw_idx) is loaded with all fields and V=1 at the edge.
- Round-robin pointer: rr_ptr increments only when sw_we && sw_rr, and wraps ENTRIES-1 -> 0.
- Simultaneous lookup and write: the lookup sees pre-write contents; no bypass.
- Invalidation priority, highest first: sw_inv_all > sw_inv_tid > sw_we. A lower-priority write in the same cycle is dropped, and rr_ptr does not advance. sw_inv_all does not reset rr_ptr.
- sw_inv_tid clears V only where !G && T==sw_tid. Global entries survive.
- Toggling `on` mid-stream takes effect on the next sampled request; stored entries are unaffected.

Decomposition:
- pu.h gains: PU_DTLB_ENTRIES default, the PuDtlbIdxBus macro, and the entry field order {V,G,NC,K,TID,VT,PT}.
- One natural sub-module, pu_da_dtlb_cam: an ENTRIES-wide match vector, a lowest-index priority encoder and a multi-hit detect. It is purely combinational.
- The top level holds the entry storage, rr_ptr and the output registers.

Test Plan:
1. Reset, then req=1, on=0, vtag=0x12345 -> next cycle ptag=0x12345, hit=1, nc=0, miss=0.
2. Write idx 3: vtag 0x00ABC -> ptag 0x7F001, tid=1, nc=1, G=0. Then lookup on=1, tid=1, vtag=0x00ABC -> hit=1, ptag=0x7F001, nc=1. Same lookup with tid=2 -> miss=1.
3. Entry with K=1 and G=1: lookup with tmode=0 -> hit=1, fault=1; with tmode=1 -> fault=0. Any tid hits.
4. Nine sw_we with sw_rr=1 from reset -> rr_ptr 0..7, then wraps to 0, and the ninth write overwrites entry 0. The old entry-0 vtag now misses.
5. sw_inv_tid with sw_tid=1, given a tid-1 global entry and a tid-1 non-global entry -> only the global entry still hits. Then sw_inv_all together with sw_we -> all miss, and rr_ptr is unchanged.
6. Lookup and write to the same vtag in the same cycle -> miss that cycle, hit on the next lookup. Duplicate vtags at idx 2 and 5 -> ptag from idx 2, multi=1.

Source files
------------

// File: rtl/pu_da_dtlb_fa_pkg.sv
// Shared definitions for the PU data-access fully associative DTLB:
// default geometry, maintenance-operation encoding and small helpers.
package pu_da_dtlb_fa_pkg;

    localparam int PU_DTLB_ENTRIES = 8;
    localparam int PU_DC_TAG_W     = 20;
    localparam int PU_TID_W        = 2;

    // Stored entry field order, most significant first: {V,G,NC,K,TID,VT,PT}.
    typedef enum logic [1:0] {
        DTLB_OP_NONE    = 2'd0,
        DTLB_OP_WRITE   = 2'd1,
        DTLB_OP_INV_TID = 2'd2,
        DTLB_OP_INV_ALL = 2'd3
    } dtlb_op_e;

    // Only one maintenance action takes effect per cycle; invalidations win.
    function automatic dtlb_op_e dtlb_op_decode(input logic inv_all,
                                                input logic inv_tid,
                                                input logic we);
        dtlb_op_e op;
        if (inv_all) begin
            op = DTLB_OP_INV_ALL;
        end else if (inv_tid) begin
            op = DTLB_OP_INV_TID;
        end else if (we) begin
            op = DTLB_OP_WRITE;
        end else begin
            op = DTLB_OP_NONE;
        end
        return op;
    endfunction

    function automatic logic more_than_one(input logic [63:0] vec);
        return |(vec & (vec - 64'd1));
    endfunction

endpackage

// File: rtl/pu_da_dtlb_fa_cam.sv
// Combinational match array for the DTLB: per-entry compare, lowest-index
// priority select and multiple-hit detect.
module pu_da_dtlb_cam
    import pu_da_dtlb_fa_pkg::*;
#(
    parameter int  ENTRIES = PU_DTLB_ENTRIES,
    parameter int  TAG_W   = PU_DC_TAG_W,
    parameter int  TID_W   = PU_TID_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]            i_v,
    input  logic [ENTRIES-1:0]            i_g,
    input  logic [ENTRIES-1:0][TID_W-1:0] i_tid,
    input  logic [ENTRIES-1:0][TAG_W-1:0] i_vt,
    input  logic [TAG_W-1:0]              i_vtag,
    input  logic [TID_W-1:0]              i_req_tid,
    output logic [IDX_W-1:0]              o_sel,
    output logic                          o_any,
    output logic                          o_multi
);

    logic [ENTRIES-1:0] w_match;

    // Per-entry match: valid, tag equal, and either global or same thread.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_match[i] = i_v[i] && (i_vt[i] == i_vtag) &&
                         (i_g[i] || (i_tid[i] == i_req_tid));
        end
    end

    // Scanning downward leaves the lowest matching index selected.
    always_comb begin
        o_sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_sel = IDX_W'(i);
            end else begin
                o_sel = o_sel;
            end
        end
    end

    // Summary flags for the output stage.
    always_comb begin
        o_any   = |w_match;
        o_multi = more_than_one(64'(w_match));
    end

endmodule

// File: rtl/pu_da_dtlb_fa.sv
// Fully associative data TLB: entry storage, round-robin replacement pointer
// and registered lookup results (identity pass-through when translation is off).
module pu_da_dtlb_fa
    import pu_da_dtlb_fa_pkg::*;
#(
    parameter int  ENTRIES = PU_DTLB_ENTRIES,
    parameter int  TAG_W   = PU_DC_TAG_W,
    parameter int  TID_W   = PU_TID_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req,
    input  logic [TID_W-1:0] tid,
    input  logic             tmode,
    input  logic             on,
    input  logic [TAG_W-1:0] vtag,
    output logic [TAG_W-1:0] ptag,
    output logic             nc,
    output logic             hit,
    output logic             miss,
    output logic             fault,
    output logic             multi,
    input  logic             sw_we,
    input  logic             sw_rr,
    input  logic [IDX_W-1:0] sw_idx,
    input  logic [TAG_W-1:0] sw_vtag,
    input  logic [TAG_W-1:0] sw_ptag,
    input  logic [TID_W-1:0] sw_tid,
    input  logic             sw_glb,
    input  logic             sw_nc,
    input  logic             sw_kern,
    input  logic             sw_inv_all,
    input  logic             sw_inv_tid,
    output logic [IDX_W-1:0] rr_ptr
);

    logic [ENTRIES-1:0]            r_v;
    logic [ENTRIES-1:0]            r_g;
    logic [ENTRIES-1:0]            r_nc;
    logic [ENTRIES-1:0]            r_k;
    logic [ENTRIES-1:0][TID_W-1:0] r_tid;
    logic [ENTRIES-1:0][TAG_W-1:0] r_vt;
    logic [ENTRIES-1:0][TAG_W-1:0] r_pt;
    logic [IDX_W-1:0]              r_rr;

    logic [TAG_W-1:0] r_ptag;
    logic             r_nc_o;
    logic             r_hit;
    logic             r_miss;
    logic             r_fault;
    logic             r_multi;

    dtlb_op_e           w_op;
    logic [IDX_W-1:0]   w_tgt;
    logic [ENTRIES-1:0] w_tid_kill;
    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    logic               w_multi;

    // Resolve the single maintenance action and its target slot.
    always_comb begin
        w_op       = dtlb_op_decode(sw_inv_all, sw_inv_tid, sw_we);
        w_tgt      = sw_rr ? r_rr : sw_idx;
        w_tid_kill = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_tid_kill[i] = !r_g[i] && (r_tid[i] == sw_tid);
        end
    end

    pu_da_dtlb_cam #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .TID_W   (TID_W)
    ) u_cam (
        .i_v       (r_v),
        .i_g       (r_g),
        .i_tid     (r_tid),
        .i_vt      (r_vt),
        .i_vtag    (vtag),
        .i_req_tid (tid),
        .o_sel     (w_sel),
        .o_any     (w_any),
        .o_multi   (w_multi)
    );

    // Valid bits and replacement pointer; these are the only reset storage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_v  <= '0;
            r_rr <= '0;
        end else begin
            case (w_op)
                DTLB_OP_INV_ALL: r_v <= '0;
                DTLB_OP_INV_TID: r_v <= r_v & ~w_tid_kill;
                DTLB_OP_WRITE: begin
                    r_v[w_tgt] <= 1'b1;
                    if (sw_rr) begin
                        r_rr <= r_rr + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: r_v <= r_v;
            endcase
        end
    end

    // Entry payload is meaningless while V=0, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_op == DTLB_OP_WRITE) begin
            r_g[w_tgt]   <= sw_glb;
            r_nc[w_tgt]  <= sw_nc;
            r_k[w_tgt]   <= sw_kern;
            r_tid[w_tgt] <= sw_tid;
            r_vt[w_tgt]  <= sw_vtag;
            r_pt[w_tgt]  <= sw_ptag;
        end
    end

    // Lookup result registers; ptag/nc hold across idle cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ptag  <= '0;
            r_nc_o  <= 1'b0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_fault <= 1'b0;
            r_multi <= 1'b0;
        end else if (!req) begin
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_fault <= 1'b0;
            r_multi <= 1'b0;
        end else if (!on) begin
            r_ptag  <= vtag;
            r_nc_o  <= 1'b0;
            r_hit   <= 1'b1;
            r_miss  <= 1'b0;
            r_fault <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_any) begin
            r_ptag  <= r_pt[w_sel];
            r_nc_o  <= r_nc[w_sel];
            r_hit   <= 1'b1;
            r_miss  <= 1'b0;
            r_fault <= r_k[w_sel] & ~tmode;
            r_multi <= w_multi;
        end else begin
            r_nc_o  <= 1'b0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b1;
            r_fault <= 1'b0;
            r_multi <= 1'b0;
        end
    end

    assign ptag   = r_ptag;
    assign nc     = r_nc_o;
    assign hit    = r_hit;
    assign miss   = r_miss;
    assign fault  = r_fault;
    assign multi  = r_multi;
    assign rr_ptr = r_rr;

endmodule

// File: tb/tb_pu_da_dtlb_fa.sv
// Self-checking bench for pu_da_dtlb_fa: directed scenarios with literal
// expectations plus randomized traffic against a behavioural TLB model.
module tb_pu_da_dtlb_fa;

    localparam int N  = 8;
    localparam int TW = 20;
    localparam int DW = 2;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          req, tmode, on;
    logic [DW-1:0] tid;
    logic [TW-1:0] vtag;
    logic [TW-1:0] ptag;
    logic          nc, hit, miss, fault, multi;
    logic          sw_we, sw_rr, sw_glb, sw_nc, sw_kern, sw_inv_all, sw_inv_tid;
    logic [IW-1:0] sw_idx;
    logic [TW-1:0] sw_vtag, sw_ptag;
    logic [DW-1:0] sw_tid;
    logic [IW-1:0] rr_ptr;

    pu_da_dtlb_fa dut (
        .clk(clk), .rst_(rst_), .req(req), .tid(tid), .tmode(tmode), .on(on),
        .vtag(vtag), .ptag(ptag), .nc(nc), .hit(hit), .miss(miss),
        .fault(fault), .multi(multi), .sw_we(sw_we), .sw_rr(sw_rr),
        .sw_idx(sw_idx), .sw_vtag(sw_vtag), .sw_ptag(sw_ptag),
        .sw_tid(sw_tid), .sw_glb(sw_glb), .sw_nc(sw_nc), .sw_kern(sw_kern),
        .sw_inv_all(sw_inv_all), .sw_inv_tid(sw_inv_tid), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit      mv[N];
    bit      mg[N], mnc[N], mk[N];
    int      mtid[N], mvt[N], mpt[N];
    int      mrr;
    int      e_ptag;
    bit      e_nc, e_hit, e_miss, e_fault, e_multi;

    int  nvec = 0;
    int  nerr = 0;
    bit  chk_en = 1'b0;
    int  pool[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge of the reference: lookup uses pre-edge contents, then maintenance.
    task automatic model_edge();
        int cnt, first, t;
        if (!req) begin
            e_hit = 0; e_miss = 0; e_fault = 0; e_multi = 0;
        end else if (!on) begin
            e_ptag = int'(vtag); e_nc = 0; e_hit = 1; e_miss = 0; e_fault = 0; e_multi = 0;
        end else begin
            cnt = 0; first = -1;
            for (int i = 0; i < N; i++) begin
                if (mv[i] && mvt[i] == int'(vtag) && (mg[i] || mtid[i] == int'(tid))) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
            if (cnt > 0) begin
                e_hit = 1; e_miss = 0; e_ptag = mpt[first]; e_nc = mnc[first];
                e_fault = mk[first] && !tmode; e_multi = (cnt > 1);
            end else begin
                e_hit = 0; e_miss = 1; e_fault = 0; e_multi = 0; e_nc = 0;
            end
        end
        if (sw_inv_all) begin
            for (int i = 0; i < N; i++) mv[i] = 0;
        end else if (sw_inv_tid) begin
            for (int i = 0; i < N; i++)
                if (!mg[i] && mtid[i] == int'(sw_tid)) mv[i] = 0;
        end else if (sw_we) begin
            t = sw_rr ? mrr : int'(sw_idx);
            mv[t] = 1; mg[t] = sw_glb; mnc[t] = sw_nc; mk[t] = sw_kern;
            mtid[t] = int'(sw_tid); mvt[t] = int'(sw_vtag); mpt[t] = int'(sw_ptag);
            if (sw_rr) mrr = (mrr + 1) % N;
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ptag",   32'(ptag),   32'(e_ptag));
            chk("nc",     32'(nc),     32'(e_nc));
            chk("hit",    32'(hit),    32'(e_hit));
            chk("miss",   32'(miss),   32'(e_miss));
            chk("fault",  32'(fault),  32'(e_fault));
            chk("multi",  32'(multi),  32'(e_multi));
            chk("rr_ptr", 32'(rr_ptr), 32'(mrr));
        end
    end

    task automatic clr();
        req = 0; tid = '0; tmode = 0; on = 0; vtag = '0;
        sw_we = 0; sw_rr = 0; sw_idx = '0; sw_vtag = '0; sw_ptag = '0; sw_tid = '0;
        sw_glb = 0; sw_nc = 0; sw_kern = 0; sw_inv_all = 0; sw_inv_tid = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic lookup(input bit o, input int t, input bit km, input int vt);
        clr(); req = 1; on = o; tid = DW'(t); tmode = km; vtag = TW'(vt);
        step();
    endtask

    task automatic wr(input bit rr, input int idx, input int vt, input int pt,
                      input int t, input bit g, input bit n, input bit k);
        clr(); sw_we = 1; sw_rr = rr; sw_idx = IW'(idx); sw_vtag = TW'(vt);
        sw_ptag = TW'(pt); sw_tid = DW'(t); sw_glb = g; sw_nc = n; sw_kern = k;
        step();
    endtask

    initial begin
        clr();
        mrr = 0; e_ptag = 0; e_nc = 0; e_hit = 0; e_miss = 0; e_fault = 0; e_multi = 0;
        for (int i = 0; i < N; i++) mv[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ptag", 32'(ptag), 32'h0);
        chk("rst_hit",  32'(hit),  32'h0);
        chk("rst_miss", 32'(miss), 32'h0);
        chk("rst_rr",   32'(rr_ptr), 32'h0);
        rst_ = 1'b1;
        chk_en = 1'b1;

        // 1: identity mode
        lookup(0, 0, 0, 'h12345);
        chk("t1_ptag", 32'(ptag), 32'h12345);
        chk("t1_hit",  32'(hit),  32'h1);
        chk("t1_nc",   32'(nc),   32'h0);
        chk("t1_miss", 32'(miss), 32'h0);

        // 2: thread-private entry
        wr(0, 3, 'h00ABC, 'h7F001, 1, 0, 1, 0);
        lookup(1, 1, 0, 'h00ABC);
        chk("t2_hit",  32'(hit),  32'h1);
        chk("t2_ptag", 32'(ptag), 32'h7F001);
        chk("t2_nc",   32'(nc),   32'h1);
        lookup(1, 2, 0, 'h00ABC);
        chk("t2_miss", 32'(miss), 32'h1);
        chk("t2_hold", 32'(ptag), 32'h7F001);

        // 3: global kernel-only entry
        wr(0, 4, 'h00DEF, 'h11111, 0, 1, 0, 1);
        lookup(1, 3, 0, 'h00DEF);
        chk("t3_hit",   32'(hit),   32'h1);
        chk("t3_fault", 32'(fault), 32'h1);
        lookup(1, 2, 1, 'h00DEF);
        chk("t3_kfault", 32'(fault), 32'h0);
        chk("t3_khit",   32'(hit),   32'h1);

        // 4: round-robin fill and wrap
        for (int i = 0; i < 9; i++) begin
            chk("t4_rr_pre", 32'(rr_ptr), 32'(i % 8));
            wr(1, 0, 'h10000 + i, 'h20000 + i, 0, 0, 0, 0);
        end
        chk("t4_rr_post", 32'(rr_ptr), 32'h1);
        lookup(1, 0, 1, 'h10000);
        chk("t4_old_miss", 32'(miss), 32'h1);
        lookup(1, 0, 1, 'h10008);
        chk("t4_new_ptag", 32'(ptag), 32'h20008);

        // 5: per-thread invalidation, then inv_all beating a write
        clr(); sw_inv_all = 1; step();
        wr(0, 0, 'h000A1, 'h0B001, 1, 1, 0, 0);
        wr(0, 1, 'h000A2, 'h0B002, 1, 0, 0, 0);
        clr(); sw_inv_tid = 1; sw_tid = 2'd1; step();
        lookup(1, 1, 1, 'h000A1);
        chk("t5_glb_hit", 32'(hit), 32'h1);
        lookup(1, 1, 1, 'h000A2);
        chk("t5_ng_miss", 32'(miss), 32'h1);
        clr(); sw_inv_all = 1; sw_we = 1; sw_rr = 1; sw_vtag = 20'h000A3; step();
        chk("t5_rr_keep", 32'(rr_ptr), 32'h1);
        lookup(1, 1, 1, 'h000A1);
        chk("t5_all_miss", 32'(miss), 32'h1);
        lookup(1, 0, 1, 'h000A3);
        chk("t5_drop_miss", 32'(miss), 32'h1);

        // 6: no bypass, and duplicate tags
        clr(); req = 1; on = 1; vtag = 20'h000B1;
        sw_we = 1; sw_idx = 3'd6; sw_vtag = 20'h000B1; sw_ptag = 20'h0C0B1; sw_glb = 1;
        step();
        chk("t6_nobyp", 32'(miss), 32'h1);
        lookup(1, 0, 1, 'h000B1);
        chk("t6_after", 32'(hit), 32'h1);
        wr(0, 5, 'h000C1, 'h55555, 0, 0, 0, 0);
        wr(0, 2, 'h000C1, 'h22222, 0, 0, 0, 0);
        lookup(1, 0, 1, 'h000C1);
        chk("t6_ptag",  32'(ptag),  32'h22222);
        chk("t6_multi", 32'(multi), 32'h1);

        // Randomized traffic over a small tag pool so hits, aliases and faults occur.
        for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(0, 32'hFFFFF));
        for (int n = 0; n < 3000; n++) begin
            clr();
            req        = ($urandom_range(0, 3) != 0);
            on         = ($urandom_range(0, 9) != 0);
            tid        = DW'($urandom_range(0, 3));
            tmode      = 1'($urandom_range(0, 1));
            vtag       = TW'(pool[$urandom_range(0, 7)]);
            sw_we      = ($urandom_range(0, 9) < 3);
            sw_rr      = 1'($urandom_range(0, 1));
            sw_idx     = IW'($urandom_range(0, 7));
            sw_vtag    = TW'(pool[$urandom_range(0, 7)]);
            sw_ptag    = TW'($urandom_range(0, 32'hFFFFF));
            sw_tid     = DW'($urandom_range(0, 3));
            sw_glb     = ($urandom_range(0, 3) == 0);
            sw_nc      = 1'($urandom_range(0, 1));
            sw_kern    = ($urandom_range(0, 3) == 0);
            sw_inv_all = ($urandom_range(0, 49) == 0);
            sw_inv_tid = ($urandom_range(0, 24) == 0);
            step();
        end

        clr();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
